// File: rtl/acc_hash_feeder_if.sv
// Key/tag input stream and hash/tag output stream of acc_hash_feeder.
interface acc_hash_feeder_if #(
  parameter int TAG_W = 16,
  parameter int NBITS = 15
);
  logic [63:0]      in_key;
  logic [TAG_W-1:0] in_tag;
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] out_hash;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_key, in_tag, in_valid, out_ready,
    output in_ready, out_hash, out_tag, out_valid
  );
  modport master (
    output in_key, in_tag, in_valid, out_ready,
    input  in_ready, out_hash, out_tag, out_valid
  );
endinterface

// File: rtl/acc_hash_feeder.sv
// Forms the key x multiplier partial products for acc_hash, carries tag/valid alongside its
// fixed latency, and re-joins tag with the returned hash in a credit-protected output FIFO.
module acc_hash_feeder #(
  parameter logic [63:0] HASH_MULT  = 64'h9E3779B97F4A7C15,
  parameter logic [63:0] ANDMSK     = 64'hffffffffffffffff,
  parameter int          NBITS      = 15,
  parameter int          TAG_W      = 16,
  parameter int          HASH_LAT   = 6,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  acc_hash_feeder_if.slave bus,
  output logic [23:0]      pp_a0b0, pp_a0b1, pp_a0b2, pp_a0b3,
  output logic [23:0]      pp_a1b0, pp_a1b1, pp_a1b2, pp_a1b3,
  output logic [23:0]      pp_a2b0, pp_a2b1, pp_a2b2,
  output logic [23:0]      pp_a3b0, pp_a3b1, pp_a3b2,
  output logic [23:0]      pp_a4b0, pp_a4b1,
  output logic [23:0]      pp_a5b0, pp_a5b1,
  output logic [23:0]      pp_a6b0,
  output logic [23:0]      pp_a7b0,
  input  logic [NBITS-1:0] hash_in
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(HASH_LAT + 2);
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  typedef struct packed {
    logic [NBITS-1:0] hash;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [63:0]                 k;
  logic                        accept, push, pop;
  logic [HASH_LAT:0]           vld_pipe;
  logic [HASH_LAT:0][TAG_W-1:0] tag_pipe;
  logic [INF_W-1:0]            inflight;
  logic [CNT_W-1:0]            fifo_cnt;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  ent_t                        mem [FIFO_DEPTH];

  function automatic logic [23:0] pp_of(input logic [63:0] key, input int i, input int j);
    return {16'b0, key[8*i +: 8]} * {8'b0, HASH_MULT[16*j +: 16]};
  endfunction

  assign k      = bus.in_key & ANDMSK;
  assign accept = bus.in_valid & bus.in_ready;
  assign push   = vld_pipe[HASH_LAT];
  assign pop    = bus.out_valid & bus.out_ready;

  // Credit: every in-flight key already owns a FIFO slot, since acc_hash cannot stall.
  assign bus.in_ready  = (SUM_W'(fifo_cnt) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
  assign bus.out_valid = fifo_cnt != '0;
  assign bus.out_hash  = bus.out_valid ? mem[rd_ptr].hash : '0;
  assign bus.out_tag   = bus.out_valid ? mem[rd_ptr].tag  : '0;

  // Products are zeroed on idle cycles so acc_hash never sees stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {pp_a0b0, pp_a0b1, pp_a0b2, pp_a0b3} <= '0;
      {pp_a1b0, pp_a1b1, pp_a1b2, pp_a1b3} <= '0;
      {pp_a2b0, pp_a2b1, pp_a2b2}          <= '0;
      {pp_a3b0, pp_a3b1, pp_a3b2}          <= '0;
      {pp_a4b0, pp_a4b1, pp_a5b0, pp_a5b1} <= '0;
      {pp_a6b0, pp_a7b0}                   <= '0;
    end else begin
      pp_a0b0 <= accept ? pp_of(k, 0, 0) : '0;
      pp_a0b1 <= accept ? pp_of(k, 0, 1) : '0;
      pp_a0b2 <= accept ? pp_of(k, 0, 2) : '0;
      pp_a0b3 <= accept ? pp_of(k, 0, 3) : '0;
      pp_a1b0 <= accept ? pp_of(k, 1, 0) : '0;
      pp_a1b1 <= accept ? pp_of(k, 1, 1) : '0;
      pp_a1b2 <= accept ? pp_of(k, 1, 2) : '0;
      pp_a1b3 <= accept ? pp_of(k, 1, 3) : '0;
      pp_a2b0 <= accept ? pp_of(k, 2, 0) : '0;
      pp_a2b1 <= accept ? pp_of(k, 2, 1) : '0;
      pp_a2b2 <= accept ? pp_of(k, 2, 2) : '0;
      pp_a3b0 <= accept ? pp_of(k, 3, 0) : '0;
      pp_a3b1 <= accept ? pp_of(k, 3, 1) : '0;
      pp_a3b2 <= accept ? pp_of(k, 3, 2) : '0;
      pp_a4b0 <= accept ? pp_of(k, 4, 0) : '0;
      pp_a4b1 <= accept ? pp_of(k, 4, 1) : '0;
      pp_a5b0 <= accept ? pp_of(k, 5, 0) : '0;
      pp_a5b1 <= accept ? pp_of(k, 5, 1) : '0;
      pp_a6b0 <= accept ? pp_of(k, 6, 0) : '0;
      pp_a7b0 <= accept ? pp_of(k, 7, 0) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[HASH_LAT-1:0], accept};
      tag_pipe <= {tag_pipe[HASH_LAT-1:0], bus.in_tag};
      inflight <= inflight + INF_W'(accept) - INF_W'(push);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{hash: hash_in, tag: tag_pipe[HASH_LAT]};
  end

  ast_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_cnt == CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_acc_hash_feeder.sv
// Bench for acc_hash_feeder with a behavioural 6-cycle acc_hash adder tree and an in-order scoreboard.
module tb_acc_hash_feeder;
  localparam logic [63:0] M = 64'h9E3779B97F4A7C15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_hash_feeder_if #(.TAG_W(16), .NBITS(15)) bus ();

  logic [23:0] pp_a0b0, pp_a0b1, pp_a0b2, pp_a0b3, pp_a1b0, pp_a1b1, pp_a1b2, pp_a1b3;
  logic [23:0] pp_a2b0, pp_a2b1, pp_a2b2, pp_a3b0, pp_a3b1, pp_a3b2;
  logic [23:0] pp_a4b0, pp_a4b1, pp_a5b0, pp_a5b1, pp_a6b0, pp_a7b0;
  logic [14:0] hash_in;

  acc_hash_feeder dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pp_a0b0(pp_a0b0), .pp_a0b1(pp_a0b1), .pp_a0b2(pp_a0b2), .pp_a0b3(pp_a0b3),
    .pp_a1b0(pp_a1b0), .pp_a1b1(pp_a1b1), .pp_a1b2(pp_a1b2), .pp_a1b3(pp_a1b3),
    .pp_a2b0(pp_a2b0), .pp_a2b1(pp_a2b1), .pp_a2b2(pp_a2b2),
    .pp_a3b0(pp_a3b0), .pp_a3b1(pp_a3b1), .pp_a3b2(pp_a3b2),
    .pp_a4b0(pp_a4b0), .pp_a4b1(pp_a4b1), .pp_a5b0(pp_a5b0), .pp_a5b1(pp_a5b1),
    .pp_a6b0(pp_a6b0), .pp_a7b0(pp_a7b0), .hash_in(hash_in)
  );

  // Behavioural acc_hash: shifted sum of products, top 15 bits, 6 register stages, no reset.
  localparam int SH [20] = '{0, 16, 32, 48, 8, 24, 40, 56, 16, 32, 48, 24, 40, 56, 32, 48, 40, 56, 48, 56};
  logic [23:0] ppv [20];
  logic [63:0] sum;
  logic [14:0] hp [1:6];
  assign ppv = '{pp_a0b0, pp_a0b1, pp_a0b2, pp_a0b3, pp_a1b0, pp_a1b1, pp_a1b2, pp_a1b3,
                 pp_a2b0, pp_a2b1, pp_a2b2, pp_a3b0, pp_a3b1, pp_a3b2,
                 pp_a4b0, pp_a4b1, pp_a5b0, pp_a5b1, pp_a6b0, pp_a7b0};
  always_comb begin
    sum = '0;
    for (int n = 0; n < 20; n++) sum = sum + ({40'b0, ppv[n]} << SH[n]);
  end
  always_ff @(posedge clk) begin
    hp[1] <= sum[63:49];
    for (int n = 2; n <= 6; n++) hp[n] <= hp[n-1];
  end
  assign hash_in = hp[6];

  int n_checks = 0, n_fail = 0, n_pop = 0;

  function automatic logic [14:0] ref_hash(input logic [63:0] key);
    logic [63:0] p;
    p = key * M;
    return p[63:49];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepts and pops sampled mid-cycle, reset drops everything in flight.
  typedef struct { logic [14:0] hash; logic [15:0] tag; } exp_t;
  exp_t exp_q [$];
  always @(negedge clk) begin
    if (!rst_n) exp_q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
        else begin
          chk("sb_hash", bus.out_hash, exp_q[0].hash);
          chk("sb_tag", bus.out_tag, exp_q[0].tag);
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back('{ref_hash(bus.in_key), bus.in_tag});
    end
  end

  typedef struct {
    logic [63:0] key;
    logic [15:0] tag;
    logic [14:0] exp_hash;
    logic [23:0] exp_a0b0;
    logic [23:0] exp_a7b0;
  } vec_t;
  vec_t vt [6];

  initial begin
    int n, p0, acc, idx;
    vt[0] = '{64'h1, 16'd5, 15'h4F1B, 24'h007C15, 24'h0};
    vt[1] = '{64'h2, 16'd6, 15'h1E37, 24'h00F82A, 24'h0};
    vt[2] = '{64'h0, 16'd7, 15'h0000, 24'h0, 24'h0};
    vt[3] = '{64'h8000_0000_0000_0000, 16'd8, 15'h4000, 24'h0, 24'h3E0A80};
    vt[4] = '{64'h0001_0000_0000_0000, 16'd9, 15'h3E0A, 24'h0, 24'h0};
    vt[5] = '{64'hFF00_0000_0000_00FF, 16'hBEEF, ref_hash(64'hFF00_0000_0000_00FF), 24'h7B98EB, 24'h7B98EB};

    rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_key = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_hash", bus.out_hash, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_pp", {pp_a0b0, pp_a3b2, pp_a7b0}, 0);
    rst_n = 1'b1;
    step();

    // Single keys with known hashes: latency, pp values, exactly one output each.
    for (int v = 0; v < 6; v++) begin
      p0 = n_pop;
      chk("vec_in_ready", bus.in_ready, 1);
      bus.in_key = vt[v].key; bus.in_tag = vt[v].tag; bus.in_valid = 1'b1;
      step();
      chk("vec_pp_a0b0", pp_a0b0, vt[v].exp_a0b0);
      chk("vec_pp_a7b0", pp_a7b0, vt[v].exp_a7b0);
      bus.in_valid = 1'b0;
      step();
      chk("vec_pp_idle", {pp_a0b0, pp_a7b0}, 0);
      n = 1;
      while (!bus.out_valid && n < 30) begin step(); n++; end
      chk("vec_latency", n, 7);
      chk("vec_hash", bus.out_hash, vt[v].exp_hash);
      chk("vec_tag", bus.out_tag, vt[v].tag);
      repeat (10) step();
      chk("vec_one_output", n_pop - p0, 1);
    end

    // Backpressure: 20 keys offered with out_ready low, only 16 credits.
    p0 = n_pop; bus.out_ready = 1'b0; acc = 0; idx = 1;
    for (int c = 0; c < 40; c++) begin
      bus.in_key = 64'(idx); bus.in_tag = 16'(idx); bus.in_valid = 1'b1;
      if (bus.in_ready) begin acc++; idx++; end
      step();
    end
    chk("bp_accepted", acc, 16);
    chk("bp_in_ready_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60 && idx <= 20; c++) begin
      bus.in_key = 64'(idx); bus.in_tag = 16'(idx);
      if (bus.in_ready) idx++;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (30) step();
    chk("bp_outputs", n_pop - p0, 20);

    // Full FIFO, single pop: credit returns next cycle and is consumed by the next accept.
    bus.out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 30; c++) begin
      bus.in_key = 64'(100 + acc); bus.in_tag = 16'(100 + acc); bus.in_valid = 1'b1;
      if (bus.in_ready) acc++;
      step();
    end
    chk("full_accepted", acc, 16);
    chk("full_in_ready", bus.in_ready, 0);
    p0 = n_pop;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("full_pop_in_ready", bus.in_ready, 1);
    bus.in_key = 64'd200; bus.in_tag = 16'd200;
    step();
    chk("full_refill_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    repeat (10) step();
    chk("full_single_pop", n_pop - p0, 1);
    chk("full_still_blocked", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    repeat (30) step();
    chk("full_drained", exp_q.size(), 0);

    // Random traffic against the scoreboard.
    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_key    = {$urandom, $urandom};
      bus.in_tag    = 16'(acc);
      if (bus.in_valid && bus.in_ready) acc++;
      step();
    end
    chk("rand_accepted", acc, 1000);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (30) step();
    chk("rand_drained", exp_q.size(), 0);

    // Sustained throughput with both sides open.
    acc = 0; bus.in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      bus.in_key = {$urandom, $urandom}; bus.in_tag = 16'(c);
      if (bus.in_ready) acc++;
      step();
    end
    chk("steady_rate", acc, 60);
    bus.in_valid = 1'b0;
    repeat (30) step();
    chk("steady_drained", exp_q.size(), 0);

    // Reset with 3 entries in the FIFO and 5 keys in flight.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.in_key = 64'(c + 50); bus.in_tag = 16'(c + 50);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    chk("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_hash", bus.out_hash, 0);
    chk("mid_rst_pp", {pp_a0b0, pp_a7b0}, 0);
    step();
    rst_n = 1'b1; bus.out_ready = 1'b1;
    p0 = n_pop;
    repeat (15) step();
    chk("post_rst_no_stale", n_pop - p0, 0);
    bus.in_key = 64'h1; bus.in_tag = 16'h77; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 30) begin step(); n++; end
    chk("post_rst_hash", bus.out_hash, 15'h4F1B);
    chk("post_rst_tag", bus.out_tag, 16'h77);
    repeat (10) step();
    chk("post_rst_one_output", n_pop - p0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
